fpu_vec_checker: RTL and testbench

//  Synthesizable vector sequencer/checker for FP units (fpadd and successors).

---
 rtl/fpu_tb_pkg.sv | 22 ++
 rtl/fpu_exp_fifo.sv | 61 ++++++
 rtl/fpu_vec_checker.sv | 212 +++++++++++++++++++++
 tb/tb_fpu_vec_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_tb_pkg.sv
// Shared types and defaults for the FP unit vector sequencer/checker.
package fpu_tb_pkg;

    localparam int unsigned FLEN_DEF  = 32;
    localparam int unsigned FLAGW_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // One ROM word: {op1, op2, exp, flags_exp[7:0]}
    typedef struct packed {
        logic [FLEN_DEF-1:0] op1;
        logic [FLEN_DEF-1:0] op2;
        logic [FLEN_DEF-1:0] exp;
        logic [7:0]          flags_exp;
    } vec_t;

endpackage

// File: rtl/fpu_exp_fifo.sv
// Synchronous expected-result FIFO; first-word fall-through head, push and pop may coincide when full.
module fpu_exp_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_c,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push   = push && (!full || pop);
        do_pop    = pop && !empty;
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        head_c = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fpu_vec_checker.sv
// Streams ROM vectors into an FP unit over valid/ready and checks its in-order results.
module fpu_vec_checker
    import fpu_tb_pkg::*;
#(
    parameter int unsigned FLEN    = FLEN_DEF,
    parameter int unsigned FLAGW   = FLAGW_DEF,
    parameter int unsigned AW      = 16,
    parameter int unsigned MAXOUT  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW:0]       cfg_num,
    input  logic [2:0]        cfg_rm,
    input  logic [2:0]        cfg_op,
    input  logic [FLAGW-1:0]  cfg_flag_mask,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [3*FLEN+7:0] mem_rdata,
    output logic              dut_valid,
    input  logic              dut_ready,
    output logic [FLEN-1:0]   dut_op1,
    output logic [FLEN-1:0]   dut_op2,
    output logic [2:0]        dut_rm,
    output logic [2:0]        dut_op,
    input  logic              dut_res_valid,
    input  logic [FLEN-1:0]   dut_result,
    input  logic [FLAGW-1:0]  dut_flags,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [AW:0]       vec_count,
    output logic [AW:0]       first_err_idx,
    output logic [FLEN-1:0]   first_err_got,
    output logic              timeout,
    output logic              proto_err
);

    localparam int unsigned VW = 3 * FLEN + 8;
    localparam int unsigned FW = FLEN + FLAGW;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [CW-1:0]    num_q;
    logic [CW-1:0]    fetched;
    logic [CW-1:0]    issued;
    logic [FLAGW-1:0] mask_q;
    logic             rvalid;
    logic             skid_full;
    logic [VW-1:0]    skid_data;
    logic [TW-1:0]    drain_cnt;
    logic             err_seen;

    logic [VW-1:0]    cur_c;
    logic             have_c;
    logic             fire_c;
    logic             start_c;
    logic             pop_c;
    logic             mismatch_c;
    logic [FW-1:0]    push_data_c;
    logic [FW-1:0]    head_c;
    logic             fifo_full;
    logic             fifo_empty;

    // The ROM word is forwarded straight to the DUT when the skid is empty, so a
    // fresh fetch is only issued when nothing will still be parked after this cycle.
    always_comb begin
        start_c     = start && (state == IDLE || state == DONE);
        cur_c       = skid_full ? skid_data : mem_rdata;
        have_c      = skid_full || rvalid;
        dut_valid   = (state == RUN) && have_c && !fifo_full;
        fire_c      = dut_valid && dut_ready;
        mem_en      = (state == RUN) && (fetched < num_q) && !(have_c && !fire_c);
        mem_addr    = fetched[AW-1:0];
        dut_op1     = cur_c[3*FLEN+7 -: FLEN];
        dut_op2     = cur_c[2*FLEN+7 -: FLEN];
        push_data_c = {cur_c[FLEN+7 -: FLEN], cur_c[FLAGW-1:0]};
        pop_c       = dut_res_valid && !fifo_empty && !start_c;
        mismatch_c  = (dut_result != head_c[FW-1 -: FLEN]) ||
                      (((dut_flags ^ head_c[FLAGW-1:0]) & mask_q) != '0);
    end

    generate
        if (FLAGW < 8) begin : g_flag_pad
            logic unused_flag_bits;
            assign unused_flag_bits = ^cur_c[7:FLAGW];
        end
    endgenerate

    fpu_exp_fifo #(
        .W     (FW),
        .DEPTH (MAXOUT)
    ) u_exp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_c),
        .push      (fire_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .head_c    (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            num_q         <= '0;
            mask_q        <= '0;
            dut_rm        <= '0;
            dut_op        <= '0;
            fetched       <= '0;
            issued        <= '0;
            rvalid        <= 1'b0;
            skid_full     <= 1'b0;
            skid_data     <= '0;
            drain_cnt     <= '0;
            err_seen      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            vec_count     <= '0;
            first_err_idx <= '1;
            first_err_got <= '0;
            timeout       <= 1'b0;
            proto_err     <= 1'b0;
        end else if (start_c) begin
            num_q         <= cfg_num;
            mask_q        <= cfg_flag_mask;
            dut_rm        <= cfg_rm;
            dut_op        <= cfg_op;
            fetched       <= '0;
            issued        <= '0;
            rvalid        <= 1'b0;
            skid_full     <= 1'b0;
            drain_cnt     <= '0;
            err_seen      <= 1'b0;
            err_count     <= '0;
            vec_count     <= '0;
            first_err_idx <= '1;
            first_err_got <= '0;
            timeout       <= 1'b0;
            proto_err     <= 1'b0;
            if (cfg_num == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            rvalid <= mem_en;
            if (mem_en) fetched <= fetched + CW'(1);
            if (fire_c) issued <= issued + CW'(1);

            // Park the ROM word only when the DUT did not take it this cycle.
            if (fire_c) begin
                skid_full <= 1'b0;
            end else if (rvalid) begin
                skid_full <= 1'b1;
                skid_data <= mem_rdata;
            end

            if (dut_res_valid) begin
                if (fifo_empty) begin
                    proto_err <= 1'b1;
                end else begin
                    vec_count <= vec_count + CW'(1);
                    if (mismatch_c) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (!err_seen) begin
                            err_seen      <= 1'b1;
                            first_err_idx <= vec_count;
                            first_err_got <= dut_result;
                        end
                    end
                end
            end

            case (state)
                RUN: begin
                    if (fire_c && (issued + CW'(1) == num_q)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (pop_c) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_vec_checker.sv
// Bench for fpu_vec_checker: ROM + latency-pipelined DUT model, operand scoreboard, per-run result model.
module tb_fpu_vec_checker;
    import fpu_tb_pkg::*;

    localparam int unsigned FLEN    = 32;
    localparam int unsigned FLAGW   = 5;
    localparam int unsigned AW      = 8;
    localparam int unsigned MAXOUT  = 2;
    localparam int unsigned TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW:0]       cfg_num;
    logic [2:0]        cfg_rm;
    logic [2:0]        cfg_op;
    logic [FLAGW-1:0]  cfg_flag_mask;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [3*FLEN+7:0] mem_rdata;
    logic              dut_valid;
    logic              dut_ready;
    logic [FLEN-1:0]   dut_op1;
    logic [FLEN-1:0]   dut_op2;
    logic [2:0]        dut_rm;
    logic [2:0]        dut_op;
    logic              dut_res_valid;
    logic [FLEN-1:0]   dut_result;
    logic [FLAGW-1:0]  dut_flags;
    logic              busy;
    logic              done;
    logic [15:0]       err_count;
    logic [AW:0]       vec_count;
    logic [AW:0]       first_err_idx;
    logic [FLEN-1:0]   first_err_got;
    logic              timeout;
    logic              proto_err;

    always #5 clk = ~clk;

    fpu_vec_checker #(
        .FLEN(FLEN), .FLAGW(FLAGW), .AW(AW), .MAXOUT(MAXOUT), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num(cfg_num), .cfg_rm(cfg_rm),
        .cfg_op(cfg_op), .cfg_flag_mask(cfg_flag_mask), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dut_valid(dut_valid), .dut_ready(dut_ready),
        .dut_op1(dut_op1), .dut_op2(dut_op2), .dut_rm(dut_rm), .dut_op(dut_op),
        .dut_res_valid(dut_res_valid), .dut_result(dut_result), .dut_flags(dut_flags),
        .busy(busy), .done(done), .err_count(err_count), .vec_count(vec_count),
        .first_err_idx(first_err_idx), .first_err_got(first_err_got),
        .timeout(timeout), .proto_err(proto_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Vector ROM, synchronous read
    vec_t rom [0:255];
    always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

    // FP unit model: result = op1^op2 unless overridden, returned after lat cycles
    int               lat = 3;
    bit               model_on = 1'b1;
    bit               ready_tog_mode = 1'b0;
    logic             ready_tog = 1'b0;
    logic             spur;
    bit               inj_en   [0:255];
    logic [FLEN-1:0]  inj_res  [0:255];
    logic [FLAGW-1:0] inj_flag [0:255];
    logic             pv [0:7];
    logic [FLEN-1:0]  pr [0:7];
    logic [FLAGW-1:0] pf [0:7];
    int               mdl_idx = 0;

    always @(posedge clk) ready_tog <= ~ready_tog;
    assign dut_ready     = ready_tog_mode ? ready_tog : 1'b1;
    assign dut_res_valid = (pv[lat-1] === 1'b1) || spur;
    assign dut_result    = pr[lat-1];
    assign dut_flags     = pf[lat-1];

    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) pv[k] <= 1'b0;
            mdl_idx <= 0;
        end else begin
            for (int k = 7; k > 0; k--) begin
                pv[k] <= pv[k-1];
                pr[k] <= pr[k-1];
                pf[k] <= pf[k-1];
            end
            pv[0] <= model_on && dut_valid && dut_ready;
            pr[0] <= inj_en[mdl_idx] ? inj_res[mdl_idx] : (dut_op1 ^ dut_op2);
            pf[0] <= inj_flag[mdl_idx];
            if (start) mdl_idx <= 0;
            else if (dut_valid && dut_ready) mdl_idx <= mdl_idx + 1;
        end
    end

    // Scoreboard: expected operands queued per run, popped on each accepted handshake
    logic [63:0] sb_q [$];
    logic [2:0]  cur_rm;
    logic [2:0]  cur_op;
    int          outstanding = 0;
    int          mem_en_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            outstanding = 0;
        end else begin
            if (start) outstanding = 0;
            if (mem_en) mem_en_cnt++;
            if (dut_valid && dut_ready) begin
                check("nofull", 64'(outstanding < int'(MAXOUT)), 64'd1);
                check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) check("ops", {dut_op1, dut_op2}, sb_q.pop_front());
                check("rm_op", 64'({dut_rm, dut_op}), 64'({cur_rm, cur_op}));
                if (model_on) outstanding++;
            end
            if (dut_res_valid && !spur) outstanding--;
        end
    end

    task automatic expect_run(input int n, input logic [FLAGW-1:0] mask, output int e_err,
                              output logic [AW:0] e_idx, output logic [FLEN-1:0] e_got);
        logic [FLEN-1:0]  got;
        logic [FLAGW-1:0] fl;
        e_err = 0;
        e_idx = '1;
        e_got = '0;
        for (int i = 0; i < n; i++) begin
            got = inj_en[i] ? inj_res[i] : (rom[i].op1 ^ rom[i].op2);
            fl  = inj_flag[i];
            if (got != rom[i].exp || ((fl ^ rom[i].flags_exp[FLAGW-1:0]) & mask) != '0) begin
                if (e_err == 0) begin
                    e_idx = (AW+1)'(i);
                    e_got = got;
                end
                e_err++;
            end
        end
    endtask

    task automatic run(input int n, input logic [2:0] rm, input logic [2:0] op,
                       input logic [FLAGW-1:0] mask, output int cycles);
        int base;
        cfg_num       = (AW+1)'(n);
        cfg_rm        = rm;
        cfg_op        = op;
        cfg_flag_mask = mask;
        cur_rm        = rm;
        cur_op        = op;
        for (int i = 0; i < n; i++) sb_q.push_back({rom[i].op1, rom[i].op2});
        base = mem_en_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 1;
        while (!done && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("done", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("mem_en_cnt", 64'(mem_en_cnt - base), 64'(n));
        sb_q.delete();
    endtask

    task automatic run_check(input string tag, input int n, input logic [2:0] rm,
                             input logic [2:0] op, input logic [FLAGW-1:0] mask);
        int               cyc;
        int               e_err;
        logic [AW:0]      e_idx;
        logic [FLEN-1:0]  e_got;
        expect_run(n, mask, e_err, e_idx, e_got);
        run(n, rm, op, mask, cyc);
        check({tag, "_vec"}, 64'(vec_count), 64'(n));
        check({tag, "_err"}, 64'(err_count), 64'(e_err));
        check({tag, "_idx"}, 64'(first_err_idx), 64'(e_idx));
        check({tag, "_got"}, 64'(first_err_got), 64'(e_got));
        check({tag, "_tmo"}, 64'(timeout), 64'd0);
        check({tag, "_proto"}, 64'(proto_err), 64'd0);
    endtask

    localparam logic [AW:0] NO_ERR = '1;

    initial begin
        int cyc;
        reset = 1'b0;
        start = 1'b0;
        spur  = 1'b0;
        cfg_num = '0;
        cfg_rm = '0;
        cfg_op = '0;
        cfg_flag_mask = '0;
        cur_rm = '0;
        cur_op = '0;
        for (int i = 0; i < 256; i++) begin
            rom[i].op1       = (i == 2) ? 32'h3F80_0000 : 32'h3F80_0000 + 32'(i) * 32'h0001_0101;
            rom[i].op2       = (i == 2) ? 32'h0 : 32'h4000_0000 + 32'(i) * 32'd7;
            rom[i].exp       = rom[i].op1 ^ rom[i].op2;
            rom[i].flags_exp = 8'h00;
            inj_en[i]   = 1'b0;
            inj_res[i]  = '0;
            inj_flag[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_vec", 64'(vec_count), 64'd0);
        check("rst_idx", 64'(first_err_idx), 64'(NO_ERR));
        check("rst_flags", 64'({timeout, proto_err, mem_en, dut_valid}), 64'd0);
        reset = 1'b1;

        // Result strobe with nothing outstanding
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        check("spurious_proto", 64'(proto_err), 64'd1);

        // Empty run: done one cycle after start, no fetch
        run(0, 3'd2, 3'd1, 5'h1F, cyc);
        check("num0_latency", 64'(cyc), 64'd1);
        check("num0_vec", 64'(vec_count), 64'd0);
        check("num0_proto", 64'(proto_err), 64'd0);

        run_check("clean4", 4, 3'd1, 3'd0, 5'h1F);

        inj_en[2]  = 1'b1;
        inj_res[2] = 32'h3F80_0001;
        run_check("res_err", 4, 3'd3, 3'd2, 5'h1F);
        check("res_err_got_lit", 64'(first_err_got), 64'h3F80_0001);
        inj_en[2] = 1'b0;

        inj_flag[1] = 5'b00001;
        run_check("flag_m1", 4, 3'd0, 3'd0, 5'b00001);
        check("flag_m1_idx_lit", 64'(first_err_idx), 64'd1);
        run_check("flag_m0", 4, 3'd0, 3'd0, 5'b00000);
        inj_flag[1] = '0;

        // Backpressure and longer latency
        lat = 5;
        ready_tog_mode = 1'b1;
        run_check("tog16", 16, 3'd4, 3'd5, 5'h1F);

        // DUT never answers
        model_on = 1'b0;
        ready_tog_mode = 1'b0;
        run(2, 3'd1, 3'd1, 5'h1F, cyc);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_vec", 64'(vec_count), 64'd0);
        check("tmo_window", 64'(cyc >= int'(TIMEOUT) && cyc <= int'(TIMEOUT) + 10), 64'd1);
        model_on = 1'b1;

        // Reset in the middle of a run
        ready_tog_mode = 1'b1;
        cfg_num = (AW+1)'(16);
        cur_rm = 3'd6;
        cur_op = 3'd3;
        cfg_rm = 3'd6;
        cfg_op = 3'd3;
        for (int i = 0; i < 16; i++) sb_q.push_back({rom[i].op1, rom[i].op2});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_vec", 64'(vec_count), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        check("mid_rst_idx", 64'(first_err_idx), 64'(NO_ERR));
        sb_q.delete();
        reset = 1'b1;
        ready_tog_mode = 1'b0;
        lat = 3;
        run_check("after_rst", 4, 3'd1, 3'd2, 5'h1F);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
